prog_clk_div: RTL and testbench

//  Runtime-programmable clock-enable generator. Successor to the fixed divide-by-8 divider.

---
 rtl/prog_clk_div.sv | 81 ++++++++
 tb/tb_prog_clk_div.sv | 134 +++++++++++++
 2 files changed

// File: rtl/prog_clk_div.sv
// Runtime-programmable clock-enable generator: counts 1..N on enabled edges,
// emits a tick at N and an optional square wave; divisor reloads only at period boundaries.
module prog_clk_div #(
  parameter int NUM_BITS    = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic                sysclk,
  input  logic                n_rst,
  input  logic                enable,
  input  logic                load,
  input  logic [NUM_BITS-1:0] div_val,
  input  logic                mode,
  input  logic                sync,
  output logic                tick,
  output logic                clk,
  output logic [NUM_BITS-1:0] count_out,
  output logic                pending
);

  localparam logic [NUM_BITS-1:0] DIV_RST = NUM_BITS'(DEFAULT_DIV);
  localparam logic [NUM_BITS-1:0] DIV_MIN = NUM_BITS'(2);

  logic [NUM_BITS-1:0] count_q, count_d;
  logic [NUM_BITS-1:0] active_q, active_d;
  logic [NUM_BITS-1:0] pdiv_q, pdiv_d;
  logic                pend_q, pend_d;
  logic                tick_q, tick_d;
  logic                clk_q, clk_d;
  logic [NUM_BITS-1:0] ld_val;
  logic                rollover, apply;

  always_comb begin
    ld_val   = (div_val < DIV_MIN) ? DIV_MIN : div_val;
    // >= rather than == keeps the count bounded if a smaller divisor lands
    // while the counter is frozen above it.
    rollover = enable && !sync && (count_q >= active_q);
    apply    = rollover || (count_q == '0) || !enable || sync;

    pdiv_d   = load ? ld_val : pdiv_q;
    pend_d   = load | pend_q;
    active_d = active_q;
    if (apply) begin
      active_d = pdiv_d;
      pend_d   = 1'b0;
    end

    count_d = count_q;
    if (sync)          count_d = '0;
    else if (enable)   count_d = rollover ? NUM_BITS'(1) : count_q + NUM_BITS'(1);

    tick_d = enable && !sync && (count_d == active_d);

    clk_d = clk_q;
    if (sync)          clk_d = 1'b0;
    else if (enable)   clk_d = mode ? ((count_d != '0) && (count_d <= (active_d >> 1))) : tick_d;
  end

  always_ff @(posedge sysclk or negedge n_rst) begin
    if (!n_rst) begin
      count_q  <= '0;
      active_q <= DIV_RST;
      pdiv_q   <= DIV_RST;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      pdiv_q   <= pdiv_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      clk_q    <= clk_d;
    end
  end

  assign tick      = tick_q;
  assign clk       = clk_q;
  assign count_out = count_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div: hand-computed count/tick/clk/pending sequences.
module tb_prog_clk_div;

  logic       sysclk = 1'b0;
  logic       n_rst, enable, load, mode, sync;
  logic [7:0] div_val;
  logic       tick, clk, pending;
  logic [7:0] count_out;
  int         errs = 0;
  int         checks = 0;

  prog_clk_div #(.NUM_BITS(8), .DEFAULT_DIV(8)) dut (
    .sysclk(sysclk), .n_rst(n_rst), .enable(enable), .load(load),
    .div_val(div_val), .mode(mode), .sync(sync),
    .tick(tick), .clk(clk), .count_out(count_out), .pending(pending)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input bit t, input bit k, input bit p);
    chk({tag, ".count"}, 32'(count_out), 32'(c));
    chk({tag, ".tick"}, 32'(tick), 32'(t));
    chk({tag, ".clk"}, 32'(clk), 32'(k));
    chk({tag, ".pending"}, 32'(pending), 32'(p));
  endtask

  initial begin
    n_rst = 1'b0; enable = 1'b0; load = 1'b0; mode = 1'b0; sync = 1'b0; div_val = 8'd0;
    #12;
    chk_all("reset", 0, 0, 0, 0);
    n_rst = 1'b1; enable = 1'b1;

    // N=8 pulse mode: counts 1..8, tick on 8th edge
    for (int i = 1; i <= 40; i++) begin
      step();
      chk_all("div8", ((i - 1) % 8) + 1, ((i % 8) == 0), ((i % 8) == 0), 0);
    end

    // load 5 on a rollover edge: applied directly, square wave 2 high / 3 low
    load = 1'b1; div_val = 8'd5; mode = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      load = 1'b0;
      chk_all("div5sq", ((i - 1) % 5) + 1, ((i % 5) == 0), (((i - 1) % 5) < 2), 0);
    end

    // back to N=8 (rollover edge again), pulse mode
    load = 1'b1; div_val = 8'd8; mode = 1'b0;
    step(); load = 1'b0;
    chk_all("back8", 1, 0, 0, 0);
    step(); step();
    chk("at3", 32'(count_out), 3);

    // load 12 mid-period: pending until count 8, period unchanged
    load = 1'b1; div_val = 8'd12;
    step(); load = 1'b0;
    chk_all("ld12", 4, 0, 0, 1);
    for (int c = 5; c <= 8; c++) begin
      step();
      chk_all("pend12", c, (c == 8), (c == 8), 1);
    end
    step();
    chk_all("apply12", 1, 0, 0, 0);
    for (int c = 2; c <= 12; c++) begin
      step();
      chk_all("div12", c, (c == 12), (c == 12), 0);
    end

    // sync at count 6 of N=12, square mode
    mode = 1'b1;
    for (int c = 1; c <= 6; c++) step();
    chk_all("presync", 6, 0, 1, 0);
    sync = 1'b1;
    step(); sync = 1'b0;
    chk_all("sync", 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk_all("postsync", c, (c == 12), (c <= 6), 0);
    end

    // div_val 0 then 1: both clamp to N=2
    load = 1'b1; div_val = 8'd0;
    for (int i = 1; i <= 4; i++) begin
      step(); load = 1'b0;
      chk_all("div0", ((i - 1) % 2) + 1, ((i % 2) == 0), ((i % 2) == 1), 0);
    end
    load = 1'b1; div_val = 8'd1;
    for (int i = 1; i <= 4; i++) begin
      step(); load = 1'b0;
      chk_all("div1", ((i - 1) % 2) + 1, ((i % 2) == 0), ((i % 2) == 1), 0);
    end

    // N=8, freeze at count 4 for 10 cycles
    load = 1'b1; div_val = 8'd8; mode = 1'b0;
    step(); load = 1'b0;
    step(); step(); step();
    chk("at4", 32'(count_out), 4);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("frozen", 4, 0, 0, 0);
    end

    // asynchronous reset mid-cycle, then default divisor 8 again
    enable = 1'b1;
    step(); step();
    chk("at6", 32'(count_out), 6);
    #2 n_rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    #2 n_rst = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      chk_all("rst_div8", ((c - 1) % 8) + 1, (c == 8), (c == 8), 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
